// File: rtl/gat_layer_sequencer.sv
// Sequences multi-layer GAT inference on gat_top, then drains the new-feature
// BRAM onto a valid/ready stream through a small credit-limited read FIFO.
module gat_layer_sequencer #(
  parameter int NUM_LAYERS         = 2,
  parameter int FEAT_WORDS         = 43328,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int READ_LATENCY       = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int TIMEOUT_CYCLES     = 1 << 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          h_data_bram_load_done,
  input  logic                          h_node_info_bram_load_done,
  input  logic                          wgt_bram_load_done,
  output logic                          core_load_done,
  output logic                          gat_layer,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [7:0]                    layer_idx
);
  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int DW = NEW_FEATURE_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOAD, S_WAIT_BUSY, S_WAIT_READY, S_NEXT, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_layer_idx;
  logic          r_busy, r_done, r_err, r_core_ld, r_gat_layer;
  logic          r_wgt_d, r_wgt_seen;

  logic [AW-1:0] r_word_idx;
  logic          r_issued_all;
  logic [RL-1:0] r_rd_vld, r_rd_last;
  logic [DW:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_wgt_rise, w_load_ok, w_tmo;
  logic [CW-1:0] w_in_flight;
  logic          w_issue, w_push, w_pop, w_last_word;
  logic [DW:0]   w_head;

  assign w_wgt_rise = wgt_bram_load_done & ~r_wgt_d;
  // Later layers need a fresh weight load, seen as a new rising edge of the flag.
  assign w_load_ok  = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done &
                      ((r_layer_idx == 8'd0) | r_wgt_seen | w_wgt_rise);
  assign w_tmo      = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RL; i++) w_in_flight = w_in_flight + CW'(r_rd_vld[i]);
  end

  // Reads in the BRAM delay line count against FIFO space so nothing can overflow.
  assign w_issue     = (r_state == S_DRAIN) && !r_issued_all &&
                       ((w_in_flight + r_count) < CW'(FIFO_DEPTH));
  assign w_push      = r_rd_vld[RL-1];
  assign w_pop       = (r_count != '0) && m_ready;
  assign w_last_word = (r_word_idx == AW'(FEAT_WORDS - 1));
  assign w_head      = r_fifo[r_rd_ptr];

  assign m_valid         = (r_count != '0);
  assign m_data          = m_valid ? w_head[DW-1:0] : '0;
  assign m_last          = m_valid & w_head[DW];
  assign feat_bram_addrb = {r_word_idx, 2'b00};
  assign core_load_done  = r_core_ld;
  assign gat_layer       = r_gat_layer;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err_timeout     = r_err;
  assign layer_idx       = r_layer_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_layer_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_core_ld   <= 1'b0;
      r_gat_layer <= 1'b0;
      r_wgt_d     <= 1'b0;
      r_wgt_seen  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_wgt_d    <= wgt_bram_load_done;
      r_wgt_seen <= (r_state == S_NEXT) ? w_wgt_rise : (r_wgt_seen | w_wgt_rise);
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_state     <= S_WAIT_LOAD;
            r_layer_idx <= '0;
            r_gat_layer <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        S_WAIT_LOAD: begin
          if (w_load_ok) begin
            r_core_ld <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY, S_WAIT_READY: begin
          if ((r_state == S_WAIT_BUSY) && !gat_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT_READY;
          end else if ((r_state == S_WAIT_READY) && gat_ready) begin
            r_layer_idx <= r_layer_idx + 8'd1;
            r_core_ld   <= 1'b0;
            r_state     <= (r_layer_idx < 8'(NUM_LAYERS - 1)) ? S_NEXT : S_DRAIN;
          end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_core_ld <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_NEXT: begin
          r_gat_layer <= r_layer_idx[0];
          r_state     <= S_WAIT_LOAD;
        end
        S_DRAIN: begin
          if (w_pop && w_head[DW]) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_idx   <= '0;
      r_issued_all <= 1'b0;
      r_rd_vld     <= '0;
      r_rd_last    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_rd_vld[0]  <= w_issue;
      r_rd_last[0] <= w_issue & w_last_word;
      for (int i = 1; i < RL; i++) begin
        r_rd_vld[i]  <= r_rd_vld[i-1];
        r_rd_last[i] <= r_rd_last[i-1];
      end
      if (r_state != S_DRAIN) begin
        r_word_idx   <= '0;
        r_issued_all <= 1'b0;
      end else if (w_issue) begin
        if (w_last_word) r_issued_all <= 1'b1;
        else             r_word_idx   <= r_word_idx + 1'b1;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_rd_last[RL-1], feat_bram_dout};
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Randomized bench: a scripted host/core/BRAM environment drives the sequencer and
// a scoreboard of expected feature words checks the output stream.
module tb_gat_layer_sequencer;
  localparam int NL = 2;
  localparam int FW = 8;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, start, h_ld, n_ld, w_ld, gat_ready, m_ready;
  logic          core_load_done, gat_layer, m_valid, m_last, busy, done, err_timeout;
  logic [AW+1:0] feat_bram_addrb;
  logic [DW-1:0] feat_bram_dout, m_data, salt;
  logic [7:0]    layer_idx;

  gat_layer_sequencer #(
    .NUM_LAYERS(NL), .FEAT_WORDS(FW), .NEW_FEATURE_WIDTH(DW), .NEW_FEATURE_ADDR_W(AW),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(n_ld),
    .wgt_bram_load_done(w_ld), .core_load_done(core_load_done), .gat_layer(gat_layer),
    .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .err_timeout(err_timeout), .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // BRAM: word w holds salt ^ {w, w}, valid RL cycles after the address.
  logic [AW+1:0] bp [RL];
  always @(posedge clk) begin
    bp[0] <= feat_bram_addrb;
    for (int i = 1; i < RL; i++) bp[i] <= bp[i-1];
  end
  logic [AW-1:0] bp_word;
  assign bp_word        = bp[RL-1][AW+1:2];
  assign feat_bram_dout = salt ^ {16'(bp_word), 16'(bp_word)};

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  word_t exp_q[$];
  bit    mon_en = 0, lat_chk = 0;
  int    hs_cnt = 0, done_cnt = 0, d_cyc = 0;
  bit    prev_stall = 0, prev_last_hs = 0;
  logic [DW-1:0] prev_data;
  logic  prev_last;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("done_pulse", done, prev_last_hs);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_word", m_valid, 0);
        else begin
          word_t e;
          e = exp_q.pop_front();
          chk("data", m_data, e.data);
          chk("last", m_last, e.last);
          if (lat_chk) chk("word_cycle", cnt, d_cyc + RL + 1 + hs_cnt);
          hs_cnt++;
        end
      end
      prev_stall   = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
      prev_last_hs = m_valid && m_ready && m_last;
      if (done) done_cnt++;
    end
  end

  task automatic chk_zero(input string t);
    @(negedge clk);
    chk({t, "_busy"}, busy, 0);            chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err_timeout, 0);      chk({t, "_cld"}, core_load_done, 0);
    chk({t, "_glayer"}, gat_layer, 0);     chk({t, "_lidx"}, layer_idx, 0);
    chk({t, "_mvalid"}, m_valid, 0);       chk({t, "_mdata"}, m_data, 0);
    chk({t, "_mlast"}, m_last, 0);         chk({t, "_addr"}, feat_bram_addrb, 0);
  endtask

  task automatic wait_cld();
    int n = 0;
    forever begin
      @(negedge clk);
      if (core_load_done) break;
      if (++n > 40) begin chk("cld_wait_timeout", core_load_done, 1); break; end
    end
  endtask

  task automatic start_run();
    salt = $urandom;
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_lidx", layer_idx, 0);
  endtask

  task automatic do_layer(input int l, input bit ign, input bit reload, input bit last);
    if (l == 0) begin
      if (!(h_ld && n_ld && w_ld)) begin
        h_ld = 1'b1; n_ld = 1'b1; w_ld = 1'b0;
        repeat (3) cyc();
        @(negedge clk); chk("ld_partial", core_load_done, 0);
        cyc(); w_ld = 1'b1;
      end
    end else begin
      if (reload) begin
        repeat (4) cyc();
        @(negedge clk); chk("ld_reload_hold", core_load_done, 0);
      end
      cyc(); w_ld = 1'b0;
      repeat (2) cyc(); w_ld = 1'b1;
    end
    wait_cld();
    chk("gat_layer", gat_layer, l % 2);
    chk("layer_idx", layer_idx, l);
    cyc();
    repeat ($urandom_range(0, 3)) cyc();
    gat_ready = 1'b0;
    if (ign) begin
      cyc(); start = 1'b1;
      cyc(); start = 1'b0;
      @(negedge clk);
      chk("ign_busy", busy, 1);
      chk("ign_cld", core_load_done, 1);
      chk("ign_lidx", layer_idx, l);
      repeat (2) cyc();
    end else begin
      repeat ($urandom_range(1, 6)) cyc();
    end
    gat_ready = 1'b1;
    d_cyc = cnt + 1;
    cyc();
    @(negedge clk);
    chk("post_layer_cld", core_load_done, 0);
    if (last) begin
      chk("drain_first_addr", feat_bram_addrb, 0);
      chk("drain_lidx", layer_idx, NL);
    end
  endtask

  // mode 0: m_ready high, 1: random backpressure, 2: reset after 3 words
  task automatic drain(input int mode);
    int n;
    exp_q.delete();
    for (int w = 0; w < FW; w++) begin
      word_t e;
      e.data = salt ^ {16'(w), 16'(w)};
      e.last = (w == FW - 1);
      exp_q.push_back(e);
    end
    hs_cnt = 0; done_cnt = 0; prev_stall = 0; prev_last_hs = 0;
    lat_chk = (mode != 1);
    m_ready = 1'b1;
    mon_en  = 1;
    for (n = 0; n < 400; n++) begin
      cyc();
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      if (done_cnt > 0) break;
      if (mode == 2 && hs_cnt >= 3) break;
    end
    if (mode == 2) begin
      rst = 1'b1; mon_en = 0;
      cyc(); rst = 1'b0;
      chk_zero("mid_drain_rst");
      m_ready = 1'b0;
      return;
    end
    if (done_cnt == 0) chk("drain_timeout", done_cnt, 1);
    cyc();
    @(negedge clk);
    mon_en = 0;
    chk("done_count", done_cnt, 1);
    chk("end_busy", busy, 0);
    chk("words_left", exp_q.size(), 0);
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; h_ld = 1'b0; n_ld = 1'b0; w_ld = 1'b0;
    gat_ready = 1'b1; m_ready = 1'b0; salt = '0;
    repeat (3) cyc();
    chk_zero("reset");
    cyc(); rst = 1'b0;

    start_run();
    do_layer(0, 1, 0, 0);
    do_layer(1, 0, 0, 1);
    drain(0);

    start_run();
    do_layer(0, 0, 0, 0);
    do_layer(1, 0, 1, 1);
    drain(1);

    start_run();
    do_layer(0, 0, 0, 0);
    do_layer(1, 0, 0, 1);
    drain(2);
    start_run();
    do_layer(0, 0, 0, 0);
    do_layer(1, 0, 0, 1);
    drain(0);

    begin
      int e;
      start_run();
      wait_cld();
      e = cnt;
      repeat (15) cyc();
      @(negedge clk);
      chk("tmo_cycle", cnt - e, 15);
      chk("tmo_pre_err", err_timeout, 0);
      chk("tmo_pre_busy", busy, 1);
      cyc();
      @(negedge clk);
      chk("tmo_err", err_timeout, 1);
      chk("tmo_cld", core_load_done, 0);
      chk("tmo_busy", busy, 0);
      repeat (3) cyc();
      @(negedge clk); chk("tmo_sticky", err_timeout, 1);
      start_run();
      chk("tmo_clear", err_timeout, 0);
      do_layer(0, 0, 0, 0);
      do_layer(1, 0, 0, 1);
      drain(0);
    end

    for (int k = 0; k < 4; k++) begin
      start_run();
      do_layer(0, 0, 0, 0);
      do_layer(1, 0, k[0], 1);
      drain(int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1);
  end
endmodule

// File: doc/gat_layer_sequencer.md
# gat_layer_sequencer

Top-level controller that sequences multi-layer GAT inference on `gat_top`. It gates the host's BRAM load-done flags into the core and drives `gat_layer`. It monitors `gat_ready` with a timeout, and after the final layer drains the new-feature BRAM through a credit-based read FIFO onto a valid/ready output stream. It sits between the register bank / host DMA and the `gat_top_wrapper` instance.

## Interface
Parameters:
- `NUM_LAYERS`, 2: layers to run; `gat_layer` = layer index LSB.
- `FEAT_WORDS`, 43328: words drained from the feature BRAM after the last layer (NUM_SUBGRAPHS*NUM_FEATURE_OUT).
- `NEW_FEATURE_WIDTH`, 32: feature word width.
- `NEW_FEATURE_ADDR_W`, 16: word-address width (`$clog2(FEAT_WORDS)`).
- `READ_LATENCY`, 2: cycles from `feat_bram_addrb` to valid `feat_bram_dout`.
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ READ_LATENCY+1.
- `TIMEOUT_CYCLES`, 2^24: maximum cycles per core handshake phase.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle run request from the register bank.
- `h_data_bram_load_done`, `h_node_info_bram_load_done`, `wgt_bram_load_done`  in  1 each  host load flags.
- `core_load_done`  out  1  drives all three core load-done inputs.
- `gat_layer`  out  1  layer select to the core.
- `gat_ready`  in  1  core status; low while computing, high when idle/finished.
- `feat_bram_addrb`  out  NEW_FEATURE_ADDR_W+2  byte address = {word_idx, 2'b00}.
- `feat_bram_dout`  in  NEW_FEATURE_WIDTH  read data.
- `m_data`  out  NEW_FEATURE_WIDTH; `m_valid`  out  1; `m_ready`  in  1; `m_last`  out  1: output stream.
- `busy`  out  1; `done`  out  1 (pulse); `err_timeout`  out  1 (sticky); `layer_idx`  out  8.

## Operation
- States: IDLE, WAIT_LOAD, WAIT_BUSY, WAIT_READY, NEXT, DRAIN, DONE, ERR.
- **IDLE:** `start` → WAIT_LOAD, `layer_idx`=0, `busy`=1.
- **WAIT_LOAD:**
  - Layer 0 requires all three flags high.
  - Layer >0 additionally requires a rising edge of `wgt_bram_load_done` observed since entering NEXT (the host reloads weights).
  - On satisfaction: `core_load_done`=1 → WAIT_BUSY.
- **WAIT_BUSY:** wait for `gat_ready`=0 → WAIT_READY.
- **WAIT_READY:** wait for `gat_ready`=1. Then `layer_idx`++; go to NEXT if `layer_idx`<NUM_LAYERS-1, else DRAIN.
- **NEXT:** `core_load_done`=0 for one cycle, edge detector armed → WAIT_LOAD.
- `gat_layer` = `layer_idx[0]`, updated on entry to WAIT_LOAD.
- **Timeout:** a per-phase cycle counter clears on entering WAIT_BUSY and WAIT_READY. Reaching TIMEOUT_CYCLES → ERR, with `err_timeout`=1, `core_load_done`=0, `busy`=0.
- **ERR:** `start` clears `err_timeout` and restarts at WAIT_LOAD with layer 0.
- **DRAIN:**
  - word_idx runs 0..FEAT_WORDS-1.
  - A read issues when `in_flight + fifo_count < FIFO_DEPTH`. `in_flight` tracks reads within the READ_LATENCY delay line, so the FIFO never overflows under any `m_ready` pattern.
  - `m_last` accompanies word FEAT_WORDS-1.
  - The FIFO head is presented on `m_data`/`m_valid`; a pop occurs on `m_valid & m_ready`.
- **DONE:** entered when the last word is accepted; `done`=1, `busy`=0, then → IDLE.
- `start` outside IDLE/ERR is ignored.
- **Reset:** all outputs are 0 the cycle after `rst` is sampled high, including mid-DRAIN. FIFO and counters are cleared.

## Timing
- `start` at cycle T → `busy`=1 at T+1; `core_load_done`=1 at the first cycle after flags are satisfied in WAIT_LOAD (registered).
- A `gat_ready` rise at cycle R → DRAIN entry at R+1 (last layer).
- First `feat_bram_addrb` at DRAIN entry D. First `m_valid` at D+READ_LATENCY+1.
- With `m_ready` held high: one word per cycle; `m_last` at D+READ_LATENCY+FEAT_WORDS.
- `done` is high for exactly one cycle, the cycle after the last handshake.
- Stream rule: `m_data`/`m_last` are held stable while `m_valid & !m_ready`.
- Simultaneous pop and push on a full FIFO is legal: count is unchanged.

## Test plan
- **Nominal 2-layer run, FEAT_WORDS=8, READ_LATENCY=2, `m_ready`=1:**
  - `gat_layer` is 0 then 1.
  - 8 words are streamed with data = address pattern, `m_last` on word 7.
  - `done` pulses once; `busy` is back to 0.
- **Backpressure:** `m_ready` toggles 1-0-0-1 randomly → no lost or duplicated word, FIFO count ≤4, `m_data` stable during stalls.
- **Timeout:** `gat_ready` held 1 after `core_load_done` with TIMEOUT_CYCLES=16 → ERR at cycle 16, `err_timeout`=1, `core_load_done`=0. A later `start` clears it.
- **Layer reload:** `wgt_bram_load_done` stays high into layer 1 → no advance until it falls and rises again.
- **Reset mid-DRAIN after 3 words:** all outputs are 0 next cycle. A new run streams from word 0.
- **Ignored start:** `start` pulsed during WAIT_READY → no state change.
